// File: rtl/fifo_flush_pkg.sv
package fifo_flush_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } flush_state_t;

  localparam int unsigned FLUSH_DISCARD = 0;
  localparam int unsigned FLUSH_DRAIN   = 1;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_flush_ptr.sv
module fifo_flush_ptr #(
  parameter int unsigned PW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clock) begin
    if (reset)     ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_flush_sync.sv
module fifo_flush_sync
  import fifo_flush_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AFULL_TH   = 28,
  parameter int unsigned FLUSH_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fifo_wr_valid_i,
  input  logic [DATA_W-1:0]        fifo_wr_data_i,
  output logic                     fifo_wr_ready_o,
  input  logic                     fifo_rd_valid_i,
  output logic [DATA_W-1:0]        fifo_rd_data_o,
  output logic                     fifo_rd_data_valid_o,
  input  logic                     fifo_flush_i,
  output logic                     fifo_flush_busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     fifo_empty_o,
  output logic                     fifo_full_o,
  output logic                     fifo_almost_full_o,
  output logic                     fifo_overflow_o,
  output logic                     fifo_underflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, count;
  flush_state_t      state_q, state_d;
  logic              idle, empty, full;
  logic              wr_en, pop, discard;
  logic              ovf_d, udf_d;

  fifo_flush_ptr #(.PW(PW)) u_wr_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (wr_en),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  fifo_flush_ptr #(.PW(PW)) u_rd_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (pop),
    .load     (discard),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  assign idle  = (state_q == ST_IDLE);
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign fifo_wr_ready_o = !full && idle && !fifo_flush_i;
  assign wr_en   = fifo_wr_valid_i && fifo_wr_ready_o && !reset;
  assign discard = (FLUSH_MODE == FLUSH_DISCARD) && idle && fifo_flush_i;
  // drain pops unconditionally: the FSM leaves DRAIN on the pop that empties the FIFO
  assign pop     = idle ? (fifo_rd_valid_i && !empty && !fifo_flush_i) : 1'b1;
  assign ovf_d   = fifo_wr_valid_i && !fifo_wr_ready_o && !(idle && fifo_flush_i);
  assign udf_d   = idle && fifo_rd_valid_i && empty && !fifo_flush_i;

  assign fifo_flush_busy_o  = !idle;
  assign fifo_count_o       = count;
  assign fifo_empty_o       = empty;
  assign fifo_full_o        = full;
  assign fifo_almost_full_o = (count >= PW'(AFULL_TH));

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= fifo_wr_data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if ((FLUSH_MODE == FLUSH_DRAIN) && fifo_flush_i && !empty) state_d = ST_DRAIN;
      ST_DRAIN: if (count == PW'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_rd_data_o       <= '0;
      fifo_rd_data_valid_o <= 1'b0;
      fifo_overflow_o      <= 1'b0;
      fifo_underflow_o     <= 1'b0;
    end else begin
      fifo_rd_data_valid_o <= pop;
      fifo_overflow_o      <= ovf_d;
      fifo_underflow_o     <= udf_d;
      if (pop) fifo_rd_data_o <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_fifo_flush_sync.sv
module tb_fifo_flush_sync;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_valid, rd_valid, flush;
  logic [7:0] wr_data;

  logic       d0_ready, d0_dv, d0_busy, d0_empty, d0_full, d0_afull, d0_ovf, d0_udf;
  logic [7:0] d0_data;
  logic [3:0] d0_count;
  logic       d1_ready, d1_dv, d1_busy, d1_empty, d1_full, d1_afull, d1_ovf, d1_udf;
  logic [7:0] d1_data;
  logic [3:0] d1_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  q[$];

  always #5 clock = ~clock;

  fifo_flush_sync #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .FLUSH_MODE(0)) d0 (
    .clock(clock), .reset(reset),
    .fifo_wr_valid_i(wr_valid), .fifo_wr_data_i(wr_data), .fifo_wr_ready_o(d0_ready),
    .fifo_rd_valid_i(rd_valid), .fifo_rd_data_o(d0_data), .fifo_rd_data_valid_o(d0_dv),
    .fifo_flush_i(flush), .fifo_flush_busy_o(d0_busy), .fifo_count_o(d0_count),
    .fifo_empty_o(d0_empty), .fifo_full_o(d0_full), .fifo_almost_full_o(d0_afull),
    .fifo_overflow_o(d0_ovf), .fifo_underflow_o(d0_udf)
  );

  fifo_flush_sync #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .FLUSH_MODE(1)) d1 (
    .clock(clock), .reset(reset),
    .fifo_wr_valid_i(wr_valid), .fifo_wr_data_i(wr_data), .fifo_wr_ready_o(d1_ready),
    .fifo_rd_valid_i(rd_valid), .fifo_rd_data_o(d1_data), .fifo_rd_data_valid_o(d1_dv),
    .fifo_flush_i(flush), .fifo_flush_busy_o(d1_busy), .fifo_count_o(d1_count),
    .fifo_empty_o(d1_empty), .fifo_full_o(d1_full), .fifo_almost_full_o(d1_afull),
    .fifo_overflow_o(d1_ovf), .fifo_underflow_o(d1_udf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] d);
    rd_valid = 1'b1;
    cyc();
    rd_valid = 1'b0;
    check_val({tag, "_dv"}, 32'(d1_dv), 32'd1);
    check_val({tag, "_data"}, 32'(d1_data), 32'(d));
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0; wr_data = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check_val("rst_count", 32'(d1_count), 32'd0);
    check_val("rst_empty", 32'(d1_empty), 32'd1);
    check_val("rst_full",  32'(d1_full),  32'd0);
    check_val("rst_afull", 32'(d1_afull), 32'd0);
    check_val("rst_busy",  32'(d1_busy),  32'd0);
    check_val("rst_ready", 32'(d1_ready), 32'd1);
    check_val("rst_dv",    32'(d1_dv),    32'd0);
    check_val("rst_data",  32'(d1_data),  32'd0);

    // fill 1..8
    for (int unsigned i = 1; i <= 8; i++) begin
      wr(8'(i));
      check_val("fill_count", 32'(d1_count), i);
      check_val("fill_afull", 32'(d1_afull), (i >= 6) ? 32'd1 : 32'd0);
    end
    check_val("fill_full",  32'(d1_full),  32'd1);
    check_val("fill_ready", 32'(d1_ready), 32'd0);

    // overflow on full
    wr_valid = 1'b1; wr_data = 8'hAA;
    #1;
    check_val("ovf_ready", 32'(d1_ready), 32'd0);
    cyc();
    wr_valid = 1'b0;
    check_val("ovf_pulse", 32'(d1_ovf), 32'd1);
    check_val("ovf_count", 32'(d1_count), 32'd8);
    cyc();
    check_val("ovf_once", 32'(d1_ovf), 32'd0);

    // drain by reads, 0xAA must not appear
    for (int unsigned i = 1; i <= 8; i++) begin
      rd_expect("read", 8'(i));
      check_val("read_count", 32'(d1_count), 8 - i);
    end
    check_val("read_empty", 32'(d1_empty), 32'd1);
    cyc();
    check_val("read_dv_off", 32'(d1_dv), 32'd0);

    // empty: simultaneous read + write
    rd_valid = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
    cyc();
    rd_valid = 1'b0; wr_valid = 1'b0;
    check_val("udf_pulse", 32'(d1_udf), 32'd1);
    check_val("udf_count", 32'(d1_count), 32'd1);
    check_val("udf_dv",    32'(d1_dv), 32'd0);
    check_val("udf_hold",  32'(d1_data), 32'h08);
    rd_expect("udf_next", 8'h55);
    check_val("udf_once", 32'(d1_udf), 32'd0);

    // discard flush with concurrent write
    do_reset();
    for (int unsigned i = 0; i < 5; i++) wr(8'(8'h30 + i));
    check_val("dis_pre", 32'(d0_count), 32'd5);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    #1;
    check_val("dis_ready", 32'(d0_ready), 32'd0);
    cyc();
    flush = 1'b0; wr_valid = 1'b0;
    check_val("dis_count", 32'(d0_count), 32'd0);
    check_val("dis_empty", 32'(d0_empty), 32'd1);
    check_val("dis_dv",    32'(d0_dv), 32'd0);
    check_val("dis_ovf",   32'(d0_ovf), 32'd0);
    check_val("dis_busy",  32'(d0_busy), 32'd0);
    cyc();
    check_val("dis_dv2",    32'(d0_dv), 32'd0);
    check_val("dis_count2", 32'(d0_count), 32'd0);

    // drain flush, with rd_valid held to show it is ignored
    do_reset();
    for (int unsigned i = 0; i < 5; i++) wr(8'(8'h10 + i));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    rd_valid = 1'b1;
    for (int unsigned k = 0; k <= 5; k++) begin
      check_val("drn_busy",  32'(d1_busy),  (k < 5) ? 32'd1 : 32'd0);
      check_val("drn_ready", 32'(d1_ready), (k < 5) ? 32'd0 : 32'd1);
      check_val("drn_dv",    32'(d1_dv),    (k >= 1) ? 32'd1 : 32'd0);
      check_val("drn_udf",   32'(d1_udf),   32'd0);
      if (k >= 1) check_val("drn_data", 32'(d1_data), 32'h10 + k - 1);
      if (k == 4) rd_valid = 1'b0;
      if (k < 5) cyc();
    end
    check_val("drn_empty", 32'(d1_empty), 32'd1);
    cyc();
    check_val("drn_dv_end", 32'(d1_dv), 32'd0);
    check_val("drn_udf_end", 32'(d1_udf), 32'd0);

    // pointer wrap, almost_full tracking
    do_reset();
    q.delete();
    for (int unsigned i = 0; i < 5; i++) begin
      wr(8'(8'hC0 + i));
      q.push_back(8'(8'hC0 + i));
    end
    for (int unsigned i = 0; i < 20; i++) begin
      logic [7:0] exp_d;
      wr(8'(8'h40 + i));
      q.push_back(8'(8'h40 + i));
      check_val("wrap_cnt_w",   32'(d1_count), 32'(q.size()));
      check_val("wrap_afull_w", 32'(d1_afull), (q.size() >= 6) ? 32'd1 : 32'd0);
      exp_d = q.pop_front();
      rd_expect("wrap", exp_d);
      check_val("wrap_cnt_r",   32'(d1_count), 32'(q.size()));
      check_val("wrap_afull_r", 32'(d1_afull), (q.size() >= 6) ? 32'd1 : 32'd0);
    end

    // reset in the middle of a drain
    do_reset();
    for (int unsigned i = 0; i < 5; i++) wr(8'(8'h20 + i));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    check_val("mid_dv", 32'(d1_dv), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_val("mid_busy",  32'(d1_busy),  32'd0);
    check_val("mid_empty", 32'(d1_empty), 32'd1);
    check_val("mid_count", 32'(d1_count), 32'd0);
    check_val("mid_dv0",   32'(d1_dv),    32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      cyc();
      check_val("mid_dv_after", 32'(d1_dv), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_flush_sync.md
Name: fifo_flush_sync

Overview:
Parametrised single-clock successor of the grey-pointer flush FIFO. It generalises width and depth and adds a ready/valid write handshake, registered read data with a valid flag, occupancy and threshold flags, and error pulses. Flush has two modes selected at elaboration: discard (clear in one cycle) and drain (stream every stored entry out, then idle). It sits between a producer and a consumer in the same clock domain and replaces ad-hoc flush FIFOs in the datapath.

Parameters:
DATA_W, 4, data width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=2
AFULL_TH, 28, fifo_almost_full_o asserts when count >= AFULL_TH (1..DEPTH)
FLUSH_MODE, 0, 0 = discard, 1 = drain

Ports:
clock  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
fifo_wr_valid_i  in  1  write request
fifo_wr_data_i  in  DATA_W  write data
fifo_wr_ready_o  out  1  write accepted this cycle when valid && ready
fifo_rd_valid_i  in  1  read (pop) request
fifo_rd_data_o  out  DATA_W  registered read data
fifo_rd_data_valid_o  out  1  fifo_rd_data_o holds a newly popped entry this cycle
fifo_flush_i  in  1  flush request, single-cycle pulse or level
fifo_flush_busy_o  out  1  drain in progress (always 0 in mode 0)
fifo_count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
fifo_empty_o  out  1  count == 0
fifo_full_o  out  1  count == DEPTH
fifo_almost_full_o  out  1  count >= AFULL_TH
fifo_overflow_o  out  1  one-cycle pulse: write attempted while not ready
fifo_underflow_o  out  1  one-cycle pulse: read attempted while empty in IDLE

Behaviour:
- Reset (sync, active-high) clears both pointers, count, state (to IDLE), rd_data_o, and all pulse outputs to 0. empty=1; full, almost_full and busy=0. Storage contents are not reset. Reset overrides every other input in the same cycle.
- Pointers are $clog2(DEPTH)+1 bits wide, binary, with an MSB wrap bit. Full: MSBs differ and the low bits are equal. Empty: pointers are equal. count = wr_ptr - rd_ptr modulo 2^(AW+1).
- fifo_wr_ready_o = !full && state==IDLE && !fifo_flush_i (combinational).
- Write: valid && ready stores the data at wr_ptr[AW-1:0] and increments wr_ptr. Write with !ready: data is dropped and overflow pulses on the next cycle.
- Read in IDLE: rd_valid && !empty && !flush_i pops rd_ptr, and the next cycle shows rd_data_o = that entry with data_valid=1 (1-cycle latency). Read while empty: no pop, underflow pulses on the next cycle, data_valid=0, rd_data_o holds its previous value.
- Simultaneous read and write in IDLE when not full and not empty: both occur, and count is unchanged. When empty, the write is accepted and the read underflows (no bypass). When full, the write is refused (ready=0) even if a read occurs.
- Pointers wrap silently at DEPTH. Read order always equals write order across the wrap.
- Flush priority: in the cycle fifo_flush_i=1, flush beats read and write; neither a user read nor a write occurs.
- FLUSH_MODE 0 (discard): with flush_i=1 in IDLE, rd_ptr <= wr_ptr, so count=0 on the next cycle. Data_valid stays 0 and no pulses fire. This is a no-op if the FIFO is already empty.
- FLUSH_MODE 1 (drain), FSM states IDLE and DRAIN:
  - IDLE -> DRAIN when flush_i=1 and count>0. With count=0 the request is a no-op and the FSM stays in IDLE.
  - In DRAIN, one entry pops every cycle starting with the first DRAIN cycle. Each pop is presented with data_valid=1 on the following cycle. busy=1 and ready=0. rd_valid_i is ignored and raises no underflow. flush_i is ignored.
  - DRAIN -> IDLE in the cycle the last entry pops (count reaches 0). busy falls with that transition. The final data_valid appears in the first IDLE cycle.
  - A flush of N entries therefore yields exactly N consecutive data_valid cycles, starting 2 cycles after the flush_i edge.
- Reset during DRAIN: immediate return to IDLE with an empty FIFO. No further data_valid is produced.

Decomposition:
- Package fifo_flush_pkg holds:
  - the FSM state typedef (ST_IDLE, ST_DRAIN);
  - constants FLUSH_DISCARD=0 and FLUSH_DRAIN=1;
  - a function that computes the pointer width from DEPTH.
- One sub-module, fifo_flush_ptr: a binary pointer with a wrap bit and ports clock, reset, inc, load, load_val, ptr. It is instantiated twice. Storage, the FSM and the flags stay in the top module.

Test Plan:
- Reset, then write 0x1..0x8 (DATA_W=8, DEPTH=8), then 8 reads -> data 0x1..0x8, each with data_valid one cycle after its read. full=1 after the 8th write; empty=1 after the 8th pop.
- Full FIFO, write 0xAA -> ready=0, overflow pulses once, count stays 8; a later readout shows 0xAA never stored.
- Empty FIFO, rd_valid and wr_valid(0x55) in the same cycle -> underflow pulses and count=1; the next read returns 0x55.
- FLUSH_MODE=0 with 5 entries, flush_i plus wr_valid in the same cycle -> count=0 and empty=1 next cycle, write dropped, no data_valid.
- FLUSH_MODE=1 with 5 entries (0x10..0x14), 1-cycle flush pulse -> busy high for 5 cycles, data_valid for 5 consecutive cycles starting 2 cycles after flush with 0x10..0x14, ready=0 throughout, then IDLE and empty.
- Pointer wrap with 20 interleaved write/read pairs at DEPTH=8 -> in-order data, and fifo_almost_full_o (AFULL_TH=6) tracks count exactly. Reset asserted mid-drain -> busy=0 and empty=1 next cycle, no further data_valid.
